// File: rtl/gate_unit_pkg.sv
// Shared types for the pipelined logic gate unit: opcode encoding and reduction-flag bundle.
package gate_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } opcode_e;

    typedef struct packed {
        logic red_and;
        logic red_or;
        logic red_xor;
    } red_flags_t;

endpackage

// File: rtl/gate_unit_pipe_if.sv
// Operand/result handshake bundle between the operand source, the gate unit and the result sink.
interface gate_unit_pipe_if
    import gate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OP_W-1:0]  in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_red_and;
    logic             out_red_or;
    logic             out_red_xor;
    logic [CNT_W-1:0] op_count;

    // Source/sink side
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_red_and, out_red_or, out_red_xor, op_count
    );

    // Gate unit side
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_red_and, out_red_or, out_red_xor, op_count
    );

endinterface

// File: rtl/gate_unit_core.sv
// Combinational bitwise op mux with reduction flags; shared by single- and multi-channel units.
module gate_unit_core
    import gate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  opcode_e          op_i,
    output logic [WIDTH-1:0] y_o,
    output red_flags_t       red_o
);

    always_comb begin
        y_o = a_i;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_NOT:  y_o = ~a_i;
            OP_PASS: y_o = a_i;
            default: y_o = a_i;
        endcase
    end

    always_comb begin
        red_o.red_and = &y_o;
        red_o.red_or  = |y_o;
        red_o.red_xor = ^y_o;
    end

endmodule

// File: rtl/gate_unit_pipe.sv
// Two-stage valid/ready pipeline around gate_unit_core with a wrapping accepted-result counter.
module gate_unit_pipe
    import gate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    gate_unit_pipe_if.slave bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    opcode_e          s1_op_q,    s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_y_q,     s2_y_d;
    red_flags_t       s2_red_q,   s2_red_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             s2_adv_c;
    logic             s1_adv_c;
    logic             accept_c;
    logic             out_fire_c;
    logic [WIDTH-1:0] core_y_c;
    red_flags_t       core_red_c;

    gate_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .op_i  (s1_op_q),
        .y_o   (core_y_c),
        .red_o (core_red_c)
    );

    // Handshake: a stage may load when it is empty or its contents move on this cycle
    always_comb begin
        s2_adv_c   = !s2_valid_q || bus.out_ready;
        s1_adv_c   = !s1_valid_q || s2_adv_c;
        accept_c   = bus.in_valid && s1_adv_c;
        out_fire_c = s2_valid_q && bus.out_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_red_d   = s2_red_q;
        cnt_d      = cnt_q;

        if (s1_adv_c) begin
            s1_valid_d = bus.in_valid;
        end
        if (accept_c) begin
            s1_a_d  = bus.in_a;
            s1_b_d  = bus.in_b;
            s1_op_d = opcode_e'(bus.in_op);
        end

        // Payload only updates on a real beat so idle outputs keep their last value
        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_y_d   = core_y_c;
                s2_red_d = core_red_c;
            end
        end

        if (out_fire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_AND;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_red_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_red_q   <= s2_red_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready    = s1_adv_c;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_y       = s2_y_q;
    assign bus.out_red_and = s2_red_q.red_and;
    assign bus.out_red_or  = s2_red_q.red_or;
    assign bus.out_red_xor = s2_red_q.red_xor;
    assign bus.op_count    = cnt_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Scoreboard bench for gate_unit_pipe: directed scenarios plus random traffic against a behavioural model.
module tb_gate_unit_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             r_and;
        logic             r_or;
        logic             r_xor;
    } exp_t;

    logic clk;
    logic rst;

    gate_unit_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gate_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] cnt_model;
    logic             held_valid;
    logic [10:0]      held_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result from the opcode table, flags from counting ones in the result
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [2:0] op);
        exp_t r;
        int   ones;
        case (op)
            3'd0: r.y = a & b;
            3'd1: r.y = a | b;
            3'd2: r.y = a ^ b;
            3'd3: r.y = ~(a & b);
            3'd4: r.y = ~(a | b);
            3'd5: r.y = ~(a ^ b);
            3'd6: r.y = ~a;
            default: r.y = a;
        endcase
        ones = 0;
        for (int i = 0; i < int'(WIDTH); i++) ones += int'(r.y[i]);
        r.r_and = (ones == int'(WIDTH));
        r.r_or  = (ones != 0);
        r.r_xor = (ones % 2) == 1;
        return r;
    endfunction

    // Monitor: handshakes are evaluated mid-cycle, before the edge that commits them
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt_model  = '0;
            held_valid = 1'b0;
        end else begin
            exp_t e;
            chk("op_count", 32'(bus.op_count), 32'(cnt_model));
            if (held_valid && bus.out_valid)
                chk("stall_hold", 32'({bus.out_y, bus.out_red_and, bus.out_red_or, bus.out_red_xor}),
                    32'(held_val));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out: got y=%0h expected no result at %0t", bus.out_y, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_y",   32'(bus.out_y),       32'(e.y));
                    chk("red_and", 32'(bus.out_red_and), 32'(e.r_and));
                    chk("red_or",  32'(bus.out_red_or),  32'(e.r_or));
                    chk("red_xor", 32'(bus.out_red_xor), 32'(e.r_xor));
                end
                cnt_model = cnt_model + CNT_W'(1);
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held_val   = {bus.out_y, bus.out_red_and, bus.out_red_or, bus.out_red_xor};
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bit acc;
        int n;
        bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_y",     32'(bus.out_y),     32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_red_or",    32'(bus.out_red_or), 32'd0);
        @(posedge clk); #1;

        // Truth-table sweep
        bus.out_ready = 1'b1;
        for (int op = 0; op < 8; op++) send(8'hF0, 8'hCC, 3'(op));
        drain();
        chk("sweep_count", 32'(bus.op_count), 32'd8);

        // Reduction corner values
        send(8'hFF, 8'hFF, 3'd0);
        send(8'h01, 8'h00, 3'd1);
        drain();

        // Backpressure
        do_reset();
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'h12, 8'h34, 3'd2);
                send(8'h56, 8'h78, 3'd1);
                send(8'h9A, 8'hBC, 3'd3);
                send(8'hDE, 8'hF0, 3'd7);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
                chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(bus.op_count), 32'd4);

        // Back-to-back streaming
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 3'($urandom);
            @(negedge clk);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            if (i >= 2) chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        drain();
        chk("stream_count", 32'(bus.op_count), 32'd12);

        // Reset with beats in flight
        bus.out_ready = 1'b0;
        send(8'hAA, 8'h55, 3'd1);
        send(8'h0F, 8'h33, 3'd2);
        do_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_y",     32'(bus.out_y),     32'd0);
        chk("mid_rst_count",     32'(bus.op_count),  32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Random traffic with random backpressure
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_a      = 8'($urandom);
            bus.in_b      = 8'($urandom);
            bus.in_op     = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Counter wrap
        do_reset();
        acc_n = 0;
        while (acc_n < 65535) begin
            bus.in_valid = 1'b1;
            bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 3'($urandom);
            @(negedge clk);
            if (bus.in_ready) acc_n++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        drain();
        chk("wrap_full", 32'(bus.op_count), 32'hFFFF);
        send(8'h3C, 8'hC3, 3'd5);
        drain();
        chk("wrap_zero", 32'(bus.op_count), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gate_unit_pipe.md
Name: gate_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit 2-input AND gate.
- Performs a selectable bitwise logic operation (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS) on two WIDTH-bit operands.
- Adds a 2-stage valid/ready pipeline, reduction flags and a completed-transaction counter.
- Sits between an operand source and a result sink in the logic-unit datapath.

Parameters:
- WIDTH, 8: operand/result width in bits (>=1).
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select, sampled with the beat.
- out_valid  output  1  result beat present.
- out_ready  input  1  sink accepts the result this cycle.
- out_y  output  WIDTH  result.
- out_red_and  output  1  &out_y.
- out_red_or  output  1  |out_y.
- out_red_xor  output  1  ^out_y (odd parity).
- op_count  output  CNT_W  number of results accepted by the sink.

Behaviour:
- Reset: synchronous, active-high. When rst=1 at a clock edge:
  - s1_valid, s2_valid and out_valid go to 0.
  - out_y goes to 0; all three reduction flags go to 0.
  - op_count goes to 0.
  - Stored operands are discarded, including beats in flight (reset mid-operation drops them).
  - in_ready reads 1 in the first cycle after reset deasserts.
- Opcodes:
  - 000 AND a&b; 001 OR a|b; 010 XOR a^b.
  - 011 NAND ~(a&b); 100 NOR ~(a|b); 101 XNOR ~(a^b).
  - 110 NOT ~a (b ignored); 111 PASS a (b ignored).
- Stage 1: registers in_a, in_b, in_op and s1_valid when a beat is accepted.
  - Accept condition: in_valid && in_ready.
- Stage 2: computes op(a,b) from the stage-1 registers and registers the result into out_y.
  - Reduction flags are computed from the same result and registered alongside it.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no other combinational in->out path).
- Latency: accepted at edge N gives out_valid=1 after edge N+1 when there is no stall. Sustained throughput is 1 beat/clk while out_ready=1.
- Stall: while out_valid && !out_ready, out_y and the flags hold stable.
  - The stage-1 beat also holds; in_ready=0 if stage 1 is full.
  - No beat is lost or duplicated.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle are both legal and both take effect.
  - The pipeline refills without a bubble.
- op_count:
  - Increments by 1 on each cycle with out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0 silently.
  - Reset takes priority over increment.
- When valid is 0, payload outputs hold their last value (don't-care to the sink). Only out_valid is meaningful.
- Undefined in_op bits (X) are a sink error; no internal checking.

Decomposition:
- Package gate_unit_pkg holds:
  - opcode typedef enum logic [2:0] {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT, OP_PASS};
  - constant OP_W = 3.
- One natural sub-module: gate_unit_core.
  - Purely combinational: WIDTH-parametrised op mux plus reduction flags.
  - Instantiated once between the two stages.
  - Reusable by later multi-channel variants.
- Pipeline registers and handshake live in the top module.

Test Plan (WIDTH=8, CNT_W=16):
1. Truth-table sweep: hold out_ready=1; a=8'hF0, b=8'hCC with op 0..7 on consecutive cycles.
   - Results appear 2 cycles after each beat in order: C0, FC, 3C, 3F, 03, C3, 0F, F0.
   - out_red_xor = 0,0,0,0,0,0,0,0; out_red_or = 1 for all.
   - op_count ends at 8.
2. Reductions: a=8'hFF, b=8'hFF, op AND -> y=FF, red_and=1, red_or=1, red_xor=0. Then a=8'h01, b=8'h00, op OR -> y=01, red_and=0, red_or=1, red_xor=1.
3. Backpressure: stream 4 beats with out_ready=0.
   - After 2 accepted beats in_ready=0, out_valid=1 and out_y stays stable.
   - Raise out_ready -> all 4 results emerge in order, none dropped.
   - op_count=4.
4. Simultaneous: with a full pipeline and out_ready=1, present in_valid every cycle for 10 cycles.
   - in_ready stays 1 throughout; 10 results arrive back-to-back.
5. Reset mid-operation: 2 beats in flight; assert rst for 1 cycle.
   - Next cycle: out_valid=0, out_y=0, op_count=0, in_ready=1.
   - No stale result is ever emitted.
6. Counter wrap: preload via 65535 handshakes (or force) -> op_count=FFFF; one more handshake -> 0000.
